load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 46 ++++
 rtl/load_store_unit_load_extend.sv | 31 +++
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared memory-length definitions for the load/store path:
//               the 3-bit access-type encoding plus helpers that derive the
//               byte count and load/store direction of an access type.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  localparam int c_MEMLEN_W = 3;

  typedef enum logic [c_MEMLEN_W-1:0] {
    MEM_NONE = 3'd0,
    MEM_LB   = 3'd1,
    MEM_LBU  = 3'd2,
    MEM_LH   = 3'd3,
    MEM_LW   = 3'd4,
    MEM_SB   = 3'd5,
    MEM_SH   = 3'd6,
    MEM_SW   = 3'd7
  } memlen_e;

  // Number of bytes moved over the byte port for an access type.
  function automatic logic [2:0] memlen_bytes(input logic [c_MEMLEN_W-1:0] len);
    logic [2:0] n;
    case (len)
      MEM_LB, MEM_LBU, MEM_SB: n = 3'd1;
      MEM_LH, MEM_SH:          n = 3'd2;
      MEM_LW, MEM_SW:          n = 3'd4;
      default:                 n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic memlen_is_store(input logic [c_MEMLEN_W-1:0] len);
    logic st;
    case (len)
      MEM_SB, MEM_SH, MEM_SW: st = 1'b1;
      default:                st = 1'b0;
    endcase
    return st;
  endfunction

endpackage : load_store_unit_pkg
`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational load-result formatter. Sign/zero-extends the
//               captured little-endian bytes according to the access type.
// Ports       : memlen - access type (package encoding)
//               bytes  - captured bytes, byte i at bits [8i+7:8i]
//               rdata  - extended 32-bit result (0 for stores / NONE)
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  memlen,
  input  logic [31:0] bytes,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = '0;
    case (memlen)
      MEM_LB:  rdata = {{24{bytes[7]}}, bytes[7:0]};
      MEM_LBU: rdata = {24'd0, bytes[7:0]};
      MEM_LH:  rdata = {{16{bytes[15]}}, bytes[15:0]};
      MEM_LW:  rdata = bytes;
      default: rdata = '0;
    endcase
  end

endmodule : load_extend
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Serialises pipeline loads/stores of 1, 2 or 4 bytes onto an
//               8-bit memory port, little-endian, with a per-byte ack timeout.
// Ports       : clk, rst                 - clock, sync active-high reset
//               req_valid/req_ready      - request handshake
//               memlen, addr, wdata      - access type, byte address, data
//               resp_valid, rdata,
//               resp_err                 - one-cycle completion response
//               mem_req, mem_we,
//               mem_addr, mem_wdata      - byte-port request
//               mem_ack, mem_rdata       - byte-port completion / read byte
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  memlen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACCESS = 2'd1;
  localparam logic [1:0] c_ST_DONE   = 2'd2;

  localparam int c_TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // The counter value seen on the final unacknowledged cycle before abort.
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;

  logic [2:0]         r_len;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_bytes;
  logic [1:0]         r_idx;
  logic [c_TMO_W-1:0] r_tmo;
  logic               r_err;

  logic [2:0]         w_nbytes;
  logic               w_last;
  logic               w_store;
  logic               w_tmo_hit;
  logic [31:0]        w_ext;

  assign w_nbytes  = memlen_bytes(r_len);
  assign w_last    = ({1'b0, r_idx} == (w_nbytes - 3'd1));
  assign w_store   = memlen_is_store(r_len);
  assign w_tmo_hit = (r_tmo == c_TMO_LAST);

  load_extend u_load_extend (
    .memlen (r_len),
    .bytes  (r_bytes),
    .rdata  (w_ext)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. An ack on the same cycle as the last timeout cycle wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (req_valid) begin
          w_next_state = (memlen == MEM_NONE) ? c_ST_DONE : c_ST_ACCESS;
        end
      end
      c_ST_ACCESS: begin
        if (mem_ack) begin
          if (w_last) begin
            w_next_state = c_ST_DONE;
          end
        end else if (w_tmo_hit) begin
          w_next_state = c_ST_DONE;
        end
      end
      c_ST_DONE: w_next_state = c_ST_IDLE;
      default:   w_next_state = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: request latch, byte capture, index and timeout tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_bytes <= '0;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (req_valid) begin
            r_len   <= memlen;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_bytes <= '0;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
          end
        end
        c_ST_ACCESS: begin
          if (mem_ack) begin
            if (!w_store) begin
              r_bytes[{r_idx, 3'b000} +: 8] <= mem_rdata;
            end
            r_idx <= r_idx + 2'd1;
            r_tmo <= '0;
          end else if (w_tmo_hit) begin
            r_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from state so everything is quiet outside its phase
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    rdata      = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (r_state)
      c_ST_IDLE: req_ready = 1'b1;
      c_ST_ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = w_store;
        mem_addr  = r_addr + {30'd0, r_idx};
        mem_wdata = r_wdata[{r_idx, 3'b000} +: 8];
      end
      c_ST_DONE: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        rdata      = r_err ? 32'd0 : w_ext;
      end
      default: ;
    endcase
  end

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A byte-addressed
//               memory model answers the byte port with configurable ack
//               delay or a stuck ack; each access is predicted from the
//               memory contents and the access-type rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  memlen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .memlen     (memlen),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  int          ack_delay  = 0;
  bit          stuck_en   = 0;
  int          stuck_from = 0;
  int          byte_no    = 0;
  int          wait_cnt   = 0;
  int          req_cycles = 0;
  bit          pending    = 0;
  logic [31:0] p_addr;
  logic [7:0]  p_wdata;
  logic        p_we;
  logic [31:0] addr_q[$];

  always @(negedge clk) begin
    if (rst || !mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      pending  = 0;
    end else begin
      req_cycles++;
      if (pending) begin
        check("hold_addr", mem_addr, p_addr);
        check("hold_wdata", {24'd0, mem_wdata}, {24'd0, p_wdata});
        check("hold_we", {31'd0, mem_we}, {31'd0, p_we});
      end
      if (!(stuck_en && byte_no >= stuck_from) && wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rd(mem_addr);
        if (mem_we) mem[mem_addr] = mem_wdata;
        addr_q.push_back(mem_addr);
        byte_no++;
        wait_cnt = 0;
        pending  = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        wait_cnt++;
        pending = 1;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        p_we    = mem_we;
      end
    end
  end

  // ---------------- one access, predicted from the rules ----------------
  task automatic do_access(input logic [2:0] len, input logic [31:0] a, input logic [31:0] wd,
                           input int d, input bit se, input int sf);
    int          n, lim, lat_exp, k, cyc_exp;
    bit          is_st, err_exp;
    logic [7:0]  old_b [4];
    logic [31:0] exp_rd;
    logic [7:0]  exp_b;

    n = (len == 3'd0) ? 0 : (len == 3'd1 || len == 3'd2 || len == 3'd5) ? 1 :
        (len == 3'd3 || len == 3'd6) ? 2 : 4;
    is_st   = (len >= 3'd5);
    err_exp = se && (sf < n);
    lim     = err_exp ? sf : n;
    for (int i = 0; i < 4; i++) old_b[i] = 8'd0;
    for (int i = 0; i < n; i++) old_b[i] = rd(a + 32'(i));

    if (err_exp) exp_rd = 32'd0;
    else begin
      case (len)
        3'd1:    exp_rd = {{24{old_b[0][7]}}, old_b[0]};
        3'd2:    exp_rd = {24'd0, old_b[0]};
        3'd3:    exp_rd = {{16{old_b[1][7]}}, old_b[1], old_b[0]};
        3'd4:    exp_rd = {old_b[3], old_b[2], old_b[1], old_b[0]};
        default: exp_rd = 32'd0;
      endcase
    end
    lat_exp = err_exp ? sf * (d + 1) + TMO + 1 : n * (d + 1) + 1;
    cyc_exp = lat_exp - 1;

    ack_delay  = d;
    stuck_en   = se;
    stuck_from = sf;
    byte_no    = 0;
    req_cycles = 0;
    addr_q.delete();

    @(negedge clk);
    check("req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    memlen    = len;
    addr      = a;
    wdata     = wd;
    @(negedge clk);
    req_valid = 1'b0;
    memlen    = 3'($urandom);
    addr      = $urandom;
    wdata     = $urandom;
    k = 1;
    while (!resp_valid && k < 200) begin
      check("idle_out", rdata | {31'd0, resp_err}, 32'd0);
      @(negedge clk);
      k++;
    end
    if (!resp_valid) begin
      check("resp_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(k), 32'(lat_exp));
      check("rdata", rdata, exp_rd);
      check("resp_err", {31'd0, resp_err}, {31'd0, err_exp});
      check("req_cycles", 32'(req_cycles), 32'(cyc_exp));
      @(negedge clk);
      check("resp_pulse", {31'd0, resp_valid}, 32'd0);
      check("ready_after", {31'd0, req_ready}, 32'd1);
    end
    check("n_acks", 32'(addr_q.size()), 32'(lim));
    for (int i = 0; i < addr_q.size() && i < lim; i++)
      check("mem_addr", addr_q[i], a + 32'(i));
    for (int i = 0; i < n; i++) begin
      exp_b = (is_st && i < lim) ? wd[8*i +: 8] : old_b[i];
      check("mem_byte", {24'd0, mem[a + 32'(i)]}, {24'd0, exp_b});
    end
  endtask

  // ---------------- reset in the middle of an SW ----------------
  task automatic reset_mid_store();
    int k;
    ack_delay  = 2;
    stuck_en   = 0;
    byte_no    = 0;
    addr_q.delete();
    @(negedge clk);
    req_valid = 1'b1;
    memlen    = 3'd7;
    addr      = 32'h0000_0300;
    wdata     = 32'h1122_3344;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (byte_no < 1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach_byte1", 32'(byte_no), 32'd1);
    @(negedge clk);
    check("rst_pre_req", {31'd0, mem_req}, 32'd1);
    check("rst_pre_addr", mem_addr, 32'h0000_0301);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_resp", {31'd0, resp_valid}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_no_resp", {31'd0, resp_valid | mem_req}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    memlen    = 3'd0;
    addr      = 32'd0;
    wdata     = 32'd0;
    mem_ack   = 1'b0;
    mem_rdata = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_outs", {30'd0, resp_valid, resp_err} | {30'd0, mem_req, mem_we}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mwdata", {24'd0, mem_wdata}, 32'd0);
    rst = 1'b0;

    mem[32'h10] = 8'h78; mem[32'h11] = 8'h56; mem[32'h12] = 8'h34; mem[32'h13] = 8'h12;
    do_access(3'd4, 32'h10, 32'h0, 0, 0, 0);
    mem[32'h40] = 8'h80;
    do_access(3'd1, 32'h40, 32'h0, 0, 0, 0);
    do_access(3'd2, 32'h40, 32'h0, 0, 0, 0);
    do_access(3'd6, 32'h20, 32'hAABBCCDD, 3, 0, 0);
    do_access(3'd4, 32'h100, 32'h0, 0, 1, 0);
    do_access(3'd4, 32'hFFFFFFFE, 32'h0, 0, 0, 0);
    do_access(3'd0, 32'h200, 32'h0, 0, 0, 0);
    do_access(3'd7, 32'h210, 32'hDEADBEEF, 1, 1, 2);
    reset_mid_store();

    for (int t = 0; t < 60; t++) begin
      logic [2:0]  l;
      logic [31:0] a;
      l = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
      do_access(l, a, $urandom, $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_load_store_unit
`default_nettype wire
